// File: rtl/dccm_pkg.sv
// ============================================================================
// dccm_pkg : definitions shared by all DCCM blocks (owner enum, widths, MMIO)
// Revision : 1.0
// ============================================================================
`default_nettype none

package dccm_pkg;

  localparam int unsigned DCCM_DW = 32;

  // Console MMIO word address (byte address 0x7f03_0000 >> 2)
  localparam logic [29:0] CONSOLE_WADDR = 30'h1fc0_c000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/dccm_arb_if.sv
// ============================================================================
// dccm_arb_if : one requester port of the DCCM arbiter (req/gnt + read return)
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dccm_arb_if #(
  parameter int AW = 32
);
  import dccm_pkg::*;

  logic               req;
  logic               we;
  logic [AW-1:0]      addr;
  logic [DCCM_DW-1:0] wdata;
  logic               gnt;
  logic               rvalid;
  logic [DCCM_DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

`default_nettype wire

// File: rtl/dccm_starve_cnt.sv
// ============================================================================
// dccm_starve_cnt : saturating counter of consecutive denied DMA cycles
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dccm_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  // clr has priority so a grant in the saturated cycle restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dccm_arb.sv
// ============================================================================
// dccm_arb : LSU/DMA arbiter for the single-port DCCM with read-data steering.
//            DCCM_ARB_STARVE_EN enables the DMA anti-starvation counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dccm_arb
  import dccm_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  dccm_arb_if.slave          lsu,
  dccm_arb_if.slave          dma,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [AW-1:0]      mem_rd_addr,
  output logic [DCCM_DW-1:0] mem_wr_data,
  input  logic [DCCM_DW-1:0] mem_rd_data
);

  logic               force_dma;
  logic               lsu_win;
  logic               dma_win;
  logic               win_wr;
  logic               win_rd;
  logic [AW-1:0]      win_addr;
  logic [DCCM_DW-1:0] win_wdata;
  owner_t             owner_q;
  owner_t             owner_d;

`ifdef DCCM_ARB_STARVE_EN
  dccm_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (dma.req && !dma_win),
    .clr    (dma_win || !dma.req),
    .at_max (force_dma)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign force_dma         = 1'b0;
`endif

  assign dma_win = dma.req && (!lsu.req || force_dma);
  assign lsu_win = lsu.req && !dma_win;
  assign lsu.gnt = lsu_win;
  assign dma.gnt = dma_win;

  always_comb begin
    win_wr    = 1'b0;
    win_rd    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (dma_win) begin
      win_wr    = dma.we;
      win_rd    = !dma.we;
      win_addr  = dma.addr;
      win_wdata = dma.wdata;
    end else if (lsu_win) begin
      win_wr    = lsu.we;
      win_rd    = !lsu.we;
      win_addr  = lsu.addr;
      win_wdata = lsu.wdata;
    end
  end

  assign mem_wr_en   = win_wr;
  assign mem_rd_en   = win_rd;
  assign mem_wr_addr = win_addr;
  assign mem_rd_addr = win_addr;
  assign mem_wr_data = win_wdata;

  // Owner of the read data returning next cycle; reloaded on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (lsu_win && !lsu.we) begin
      owner_d = OWN_LSU;
    end else if (dma_win && !dma.we) begin
      owner_d = OWN_DMA;
    end
  end

  assign lsu.rvalid = (owner_q == OWN_LSU);
  assign dma.rvalid = (owner_q == OWN_DMA);
  assign lsu.rdata  = lsu.rvalid ? mem_rd_data : '0;
  assign dma.rdata  = dma.rvalid ? mem_rd_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_dccm_arb.sv
// ============================================================================
// tb_dccm_arb : self-checking bench for dccm_arb with a behavioural dccm_mem
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dccm_arb;

`ifdef DCCM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  typedef struct {
    bit          is_dma;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t q[$];
  exp_t e;

  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  dccm_arb_if #(.AW(32)) lsu_if ();
  dccm_arb_if #(.AW(32)) dma_if ();

  dccm_arb #(
    .STARVE_MAX (4),
    .AW         (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu         (lsu_if),
    .dma         (dma_if),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Behavioural single-port memory: one-cycle synchronous read
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
    if (mem_rd_en) mem_rd_data = mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : init_val(mem_rd_addr);
  end

  // Response scoreboard: every cycle either the due read returns on its port or nothing returns
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_checks++;
      if ({lsu_if.rvalid, dma_if.rvalid, lsu_if.rdata, dma_if.rdata} !==
          (e.is_dma ? {1'b0, 1'b1, 32'h0, e.data} : {1'b1, 1'b0, e.data, 32'h0})) begin
        n_fail++;
        $display("FAIL resp_%s cyc=%0d got rv_l=%b rv_d=%b rd_l=%h rd_d=%h required data %h",
                 e.is_dma ? "dma" : "lsu", cyc, lsu_if.rvalid, dma_if.rvalid,
                 lsu_if.rdata, dma_if.rdata, e.data);
      end
    end else begin
      n_checks++;
      if ({lsu_if.rvalid, dma_if.rvalid, lsu_if.rdata, dma_if.rdata} !== 66'h0) begin
        n_fail++;
        $display("FAIL resp_idle cyc=%0d got rv_l=%b rv_d=%b rd_l=%h rd_d=%h required all 0",
                 cyc, lsu_if.rvalid, dma_if.rvalid, lsu_if.rdata, dma_if.rdata);
      end
    end
  end

  task automatic drive_idle();
    lsu_if.req = 0; lsu_if.we = 0; lsu_if.addr = '0; lsu_if.wdata = '0;
    dma_if.req = 0; dma_if.we = 0; dma_if.addr = '0; dma_if.wdata = '0;
  endtask

  // One cycle: drive at posedge+1, check grant and memory bus at negedge, return at posedge+1
  task automatic step(input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                      input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                      input bit elg, input bit edg, input string tag);
    logic [97:0] exp_bus;
    lsu_if.req = lr; lsu_if.we = lw; lsu_if.addr = la; lsu_if.wdata = ld;
    dma_if.req = dr; dma_if.we = dw; dma_if.addr = da; dma_if.wdata = dd;
    @(negedge clk);
    n_checks++;
    if ({lsu_if.gnt, dma_if.gnt} !== {elg, edg}) begin
      n_fail++;
      $display("FAIL gnt_%s cyc=%0d got lsu=%b dma=%b required lsu=%b dma=%b",
               tag, cyc, lsu_if.gnt, dma_if.gnt, elg, edg);
    end
    exp_bus = '0;
    if (elg)      exp_bus = {lw, !lw, la, la, ld};
    else if (edg) exp_bus = {dw, !dw, da, da, dd};
    n_checks++;
    if ({mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data} !== exp_bus) begin
      n_fail++;
      $display("FAIL mem_%s cyc=%0d got %h required %h", tag, cyc,
               {mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data}, exp_bus);
    end
    if (elg) begin
      if (lw) ref_mem[la] = ld;
      else    q.push_back('{is_dma: 1'b0, data: ref_rd(la), due: cyc + 1});
    end else if (edg) begin
      if (dw) ref_mem[da] = dd;
      else    q.push_back('{is_dma: 1'b1, data: ref_rd(da), due: cyc + 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lsu_if.gnt, dma_if.gnt, lsu_if.rvalid, dma_if.rvalid, lsu_if.rdata, dma_if.rdata,
         mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data} !== 166'h0) begin
      n_fail++;
      $display("FAIL reset_state got gnt=%b%b rv=%b%b mem_en=%b%b required all 0",
               lsu_if.gnt, dma_if.gnt, lsu_if.rvalid, dma_if.rvalid, mem_wr_en, mem_rd_en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_lsu_write_read();
    step(1, 1, 32'h10, 32'hdeadbeef, 0, 0, 0, 0, 1, 0, "lsu_wr");
    step(1, 0, 32'h10, 32'h0,        0, 0, 0, 0, 1, 0, "lsu_rd");
    idle(1);
  endtask

  // Both ports reading; a denied port holds its payload until granted
  task automatic run_contention(input int n, input string tag);
    int  li = 0;
    int  di = 0;
    bit  dwin;
    for (int i = 0; i < n; i++) begin
      dwin = STARVE && (i % 5 == 4);
      step(1, 0, 32'h100 + li, 0, 1, 0, 32'h200 + di, 0, !dwin, dwin, tag);
      if (dwin) di++;
      else      li++;
    end
  endtask

  task automatic test_contention();
    run_contention(15, "contend");
    idle(1);
  endtask

  task automatic test_back_to_back();
    step(1, 0, 32'h20, 0,            0, 0, 0,     0,            1, 0, "b2b_lsu");
    step(0, 0, 0,      0,            1, 0, 32'h24, 0,           0, 1, "b2b_dma");
    step(0, 0, 0,      0,            1, 1, 32'h28, 32'hcafef00d, 0, 1, "dma_wr");
    step(1, 0, 32'h28, 0,            0, 0, 0,     0,            1, 0, "raw_lsu");
    step(1, 1, 32'h2c, 32'h1234abcd, 1, 0, 32'h2c, 0,           1, 0, "wr_vs_rd");
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    run_contention(3, "pre_rst");
    step(0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 1, "rst_rd");
    q.delete(q.size() - 1);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lsu_if.gnt, dma_if.gnt, lsu_if.rvalid, dma_if.rvalid, lsu_if.rdata, dma_if.rdata,
         mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data} !== 166'h0) begin
      n_fail++;
      $display("FAIL mid_rst_outputs got rv=%b%b rd_d=%h mem_en=%b%b required all 0",
               lsu_if.rvalid, dma_if.rvalid, dma_if.rdata, mem_wr_en, mem_rd_en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    run_contention(5, "post_rst");
    idle(1);
  endtask

  task automatic test_dma_drop();
    bit dreq [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    bit dexp [8] = '{0, 0, 0, 0, 0, 0, 0, STARVE};
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 32'h180 + i, 0, dreq[i], 0, 32'h300, 0, !dexp[i], dexp[i], "drop");
    end
    idle(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    mem_rd_data = '0;
    test_reset();
    test_lsu_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    test_dma_drop();
    idle(2);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL resp_drain got %0d outstanding reads required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dccm_arb.md
# dccm_arb

Two-requester arbiter sharing the single-port data CCM between the core load/store unit (LSU) and the DMA/debug port. It issues at most one memory access per cycle, steers the synchronous read data back to the requester that owns it, and keeps DMA from starving under continuous LSU traffic. It sits between the LSU/DMA interfaces and `dccm_mem`, driving that block's write-enable, read-enable, address and write-data inputs.

## Interface
- `STARVE_MAX`, 4: consecutive denied DMA cycles before DMA is forced to win (1..15).
- `AW`, 32: word-address width.
- `clk  in  1  clock, all state on rising edge`
- `rst_n  in  1  asynchronous active-low reset`
- `lsu_req  in  1  LSU access request; held with payload until granted`
- `lsu_we  in  1  1 = write, 0 = read`
- `lsu_addr  in  AW  word address`
- `lsu_wdata  in  32  write data`
- `lsu_gnt  out  1  access accepted this cycle`
- `lsu_rvalid  out  1  read data valid (one cycle after read grant)`
- `lsu_rdata  out  32  read data`
- `dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata`: same as LSU set, for DMA.
- `mem_wr_en  out  1  to dccm_mem write enable`
- `mem_rd_en  out  1  to dccm_mem read enable`
- `mem_wr_addr, mem_rd_addr  out  AW  to dccm_mem; both driven with the winning address`
- `mem_wr_data  out  32  winning write data`
- `mem_rd_data  in  32  dccm_mem read data, valid the cycle after mem_rd_en`

## Operation
- Handshake: requester drives req plus payload; `*_gnt` is combinational in the same cycle; the transfer completes on the edge where req && gnt. Payload must stay stable while req is high and gnt is low.
- Exactly one of `lsu_gnt`/`dma_gnt` is high in any cycle with at least one request; neither is high otherwise.
- Default priority: LSU wins.
- When `force_dma` is set, DMA wins.
- `force_dma` = starvation counter == `STARVE_MAX`.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - increments on dma_req && !dma_gnt;
  - clears on dma_gnt or !dma_req;
  - saturates at `STARVE_MAX`.
- Memory drive: `mem_wr_en` = grant && we; `mem_rd_en` = grant && !we. Address and data are muxed from the winner and are 0 when idle.
- Response owner register, states:
  - NONE → LSU on an LSU read grant;
  - NONE → DMA on a DMA read grant;
  - any → NONE when there is no read grant;
  - back-to-back reads reload the register each cycle.
- `*_rvalid` asserts for exactly one cycle, on the cycle after the corresponding read grant, when the owner register equals that port.
- `*_rdata` = `mem_rd_data` when the port is the owner, else 0.
- Writes produce no rvalid.
- Same-address write then read on consecutive grants returns the new data; this follows from the memory's single-port ordering and needs no forwarding.

## Timing
- Reset values: gnt 0 (no req), rvalid 0, rdata 0, mem_* 0, counter 0, owner NONE.
- Grant latency: 0 cycles. Read latency: 1 cycle after grant. Throughput: 1 access per cycle.
- Reset asserted mid-read: an in-flight read is dropped and no rvalid is issued after reset release.
- Both requests with counter < `STARVE_MAX` → LSU granted.
- With `STARVE_MAX`=4 and continuous contention:
  - DMA is denied for 4 cycles;
  - on the 5th cycle DMA is granted and the counter clears.
- DMA dropping req while denied clears the counter; the grant is not owed.

## Configuration
- `DCCM_ARB_STARVE_EN` defined: starvation counter and `force_dma` are present, as described above.
- Not defined: strict LSU priority. The counter is removed, `force_dma` is tied to 0, and `STARVE_MAX` is ignored.

## Structure
- Shared package `dccm_pkg`:
  - owner enum (OWN_NONE, OWN_LSU, OWN_DMA);
  - DCCM data-width constant (32);
  - console MMIO word-address constant (0x7f030000>>2), so all DCCM blocks share one definition.
- One sub-module, `dccm_starve_cnt`: saturating counter with inc/clr inputs and an `at_max` output. It is instantiated only under `DCCM_ARB_STARVE_EN`.

## Test plan
- LSU write 0x0000_0010 ← 0xDEADBEEF, then LSU read 0x10:
  - gnt in the same cycle as each request;
  - mem_wr_en=1 on the write cycle;
  - lsu_rvalid=1 with 0xDEADBEEF one cycle after the read grant; dma_rvalid=0.
- LSU and DMA both reading continuously, `STARVE_MAX`=4:
  - grant pattern LSU,LSU,LSU,LSU,DMA repeating;
  - each rvalid routed to the matching port.
- Same as above without `DCCM_ARB_STARVE_EN`: DMA is never granted while lsu_req is high.
- Back-to-back reads LSU@0x20 then DMA@0x24: lsu_rvalid then dma_rvalid on consecutive cycles, each with its own word.
- rst_n pulled low the cycle after a DMA read grant: no dma_rvalid, all outputs 0; the counter restarts at 0.
- DMA req held for 2 denied cycles, dropped for 1 cycle, then reasserted: DMA is granted only after 4 further denied cycles.
